wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a granted strobe waits for slave ack before the bus-error abort.
REQ-002 SHALL have ports i_clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have ports i_arst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have master ports, for X in {0,1}: i_mX_wb_cyc in 1, i_mX_wb_stb in 1, i_mX_wb_we in 1, i_mX_wb_sel in 4, i_mX_wb_adr in 32, i_mX_wb_dat in 32. These are the master request signals; m0 is the core data port and m1 is the loader/debug master.
REQ-005 SHALL have master return ports o_mX_wb_dat out 32, o_mX_wb_ack out 1, o_mX_wb_err out 1.
REQ-006 SHALL have slave ports o_s_wb_cyc out 1, o_s_wb_stb out 1, o_s_wb_we out 1, o_s_wb_sel out 4, o_s_wb_adr out 32, o_s_wb_dat out 32, i_s_wb_dat in 32, i_s_wb_ack in 1.
REQ-007 SHALL have status ports o_grant out 2 (one-hot current owner, 00 = none) and o_timeout out 1 (one-cycle pulse on abort).

Function
REQ-008 SHALL implement a registered FSM with states IDLE, OWN0, OWN1; o_grant = 01 in OWN0, 10 in OWN1, 00 in IDLE.
REQ-009 IDLE: if exactly one i_mX_wb_cyc is high, SHALL go to OWNX on the next edge.
REQ-010 IDLE, both cyc high: SHALL grant the master not granted last (round-robin pointer last_owner), then update last_owner on grant.
REQ-011 OWNX SHALL persist while i_mX_wb_cyc=1 (bus lock across multi-beat cycles); on cyc=0 SHALL return to IDLE, giving at least one IDLE cycle between owners.
REQ-012 Grant latency SHALL be 1 cycle: cyc sampled high in IDLE at edge n -> o_s_wb_cyc high after edge n+1.
REQ-013 In OWNX, o_s_wb_cyc/stb/we/sel/adr/dat SHALL combinationally equal master X's inputs; in IDLE all slave outputs SHALL be 0.
REQ-014 o_mX_wb_dat SHALL equal i_s_wb_dat when X owns the bus, else 0.
REQ-015 o_mX_wb_ack SHALL equal i_s_wb_ack only when X owns the bus; the non-owner's ack/err SHALL be 0.
REQ-016 SHALL keep wait counter wcnt (width clog2(TIMEOUT_CYCLES+1)): increment each cycle owner stb=1 and i_s_wb_ack=0; clear on ack, on stb=0 or in IDLE.
REQ-017 When wcnt==TIMEOUT_CYCLES-1 and no ack in that cycle, then on the next cycle the arbiter SHALL: assert o_mX_wb_err for one cycle; pulse o_timeout; force o_s_wb_stb=0; clear wcnt.
REQ-018 The arbiter SHALL NOT release ownership on error; the master ends the cycle by dropping cyc.
REQ-019 Ack arriving in the same cycle the counter reaches the limit SHALL win: ack forwarded, no err, no timeout pulse.
REQ-020 i_s_wb_ack while IDLE SHALL be ignored (no master ack, no state change).
REQ-021 Owner dropping cyc mid-transfer SHALL release the bus with no ack/err generated; a late slave ack SHALL be discarded.

Reset
REQ-022 i_arst=1 SHALL immediately force state=IDLE, last_owner=1 (m0 wins first tie), wcnt=0, o_grant=00, o_timeout=0; all slave outputs and master ack/err SHALL be 0, including when reset is asserted mid-transfer.
REQ-023 After i_arst deassert, the first arbitration SHALL occur on the first rising edge with cyc high.

Verification
REQ-024 Reset, then m0 only: cyc/stb=1, adr=0x8, we=1, dat=0x15, slave ack on 2nd cycle -> o_grant=01 one cycle after request; o_s_wb_adr=0x8, o_s_wb_dat=0x15; o_m0_wb_ack=1 for one cycle; o_m1_wb_ack=0.
REQ-025 Both cyc rise together after reset -> m0 granted first; m1 gets OWN1 after m0 drops cyc plus one IDLE cycle. Repeat the simultaneous request -> m0 is granted (round-robin alternates).
REQ-026 m1 holds cyc for 3 beats with m0 requesting throughout -> o_grant stays 10 for all 3 beats; m0 never sees ack.
REQ-027 TIMEOUT_CYCLES=16, slave never acks -> after 16 stb cycles o_m0_wb_err=1 and o_timeout=1 for exactly one cycle, o_s_wb_stb=0 in that cycle; no ack. Ack on cycle 16 instead -> ack forwarded, no err.
REQ-028 i_arst pulsed mid-transfer while OWN1 -> o_grant=00 and slave outputs 0 in the same cycle; after release, pending m0 and m1 requests -> m0 granted.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant with a bus lock that lasts the whole cycle,
// and a bus-error abort on a strobe the slave never acknowledges.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_arst,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [3:0]  i_m0_wb_sel,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [31:0] i_m0_wb_dat,
    output logic [31:0] o_m0_wb_dat,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_err,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [3:0]  i_m1_wb_sel,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [31:0] i_m1_wb_dat,
    output logic [31:0] o_m1_wb_dat,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_err,

    output logic        o_s_wb_cyc,
    output logic        o_s_wb_stb,
    output logic        o_s_wb_we,
    output logic [3:0]  o_s_wb_sel,
    output logic [31:0] o_s_wb_adr,
    output logic [31:0] o_s_wb_dat,
    input  logic [31:0] i_s_wb_dat,
    input  logic        i_s_wb_ack,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              last_owner, last_owner_nx;
    logic [WCNT_W-1:0] wcnt, wcnt_nx;
    logic              abort, abort_nx;
    logic              own_cyc, own_stb;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wcnt       <= '0;
            abort      <= 1'b0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            wcnt       <= wcnt_nx;
            abort      <= abort_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        wcnt_nx       = '0;
        abort_nx      = 1'b0;
        own_cyc       = 1'b0;
        own_stb       = 1'b0;

        o_s_wb_cyc  = 1'b0;
        o_s_wb_stb  = 1'b0;
        o_s_wb_we   = 1'b0;
        o_s_wb_sel  = '0;
        o_s_wb_adr  = '0;
        o_s_wb_dat  = '0;
        o_m0_wb_dat = '0;
        o_m0_wb_ack = 1'b0;
        o_m0_wb_err = 1'b0;
        o_m1_wb_dat = '0;
        o_m1_wb_ack = 1'b0;
        o_m1_wb_err = 1'b0;
        o_grant     = 2'b00;
        o_timeout   = abort;

        case (state)
            IDLE: begin
                // On a tie, last_owner points at the master to skip.
                if (i_m0_wb_cyc && (!i_m1_wb_cyc || last_owner)) begin
                    state_nx      = OWN0;
                    last_owner_nx = 1'b0;
                end else if (i_m1_wb_cyc) begin
                    state_nx      = OWN1;
                    last_owner_nx = 1'b1;
                end
            end
            OWN0: begin
                own_cyc     = i_m0_wb_cyc;
                own_stb     = i_m0_wb_stb;
                o_grant     = 2'b01;
                o_s_wb_cyc  = i_m0_wb_cyc;
                o_s_wb_stb  = i_m0_wb_stb & ~abort;
                o_s_wb_we   = i_m0_wb_we;
                o_s_wb_sel  = i_m0_wb_sel;
                o_s_wb_adr  = i_m0_wb_adr;
                o_s_wb_dat  = i_m0_wb_dat;
                o_m0_wb_dat = i_s_wb_dat;
                o_m0_wb_ack = i_s_wb_ack & i_m0_wb_cyc & ~abort;
                o_m0_wb_err = abort;
                if (!i_m0_wb_cyc)
                    state_nx = IDLE;
            end
            OWN1: begin
                own_cyc     = i_m1_wb_cyc;
                own_stb     = i_m1_wb_stb;
                o_grant     = 2'b10;
                o_s_wb_cyc  = i_m1_wb_cyc;
                o_s_wb_stb  = i_m1_wb_stb & ~abort;
                o_s_wb_we   = i_m1_wb_we;
                o_s_wb_sel  = i_m1_wb_sel;
                o_s_wb_adr  = i_m1_wb_adr;
                o_s_wb_dat  = i_m1_wb_dat;
                o_m1_wb_dat = i_s_wb_dat;
                o_m1_wb_ack = i_s_wb_ack & i_m1_wb_cyc & ~abort;
                o_m1_wb_err = abort;
                if (!i_m1_wb_cyc)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // The abort cycle itself never counts, so the counter restarts from zero after it.
        if (own_cyc && own_stb && !i_s_wb_ack && !abort) begin
            if (wcnt == WCNT_LIMIT)
                abort_nx = 1'b1;
            else
                wcnt_nx = wcnt + WCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: grant latency, round-robin, bus lock, timeout abort, reset.
module tb_wb_arbiter_2m;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we;
    logic [3:0]  i_m0_wb_sel;
    logic [31:0] i_m0_wb_adr, i_m0_wb_dat;
    logic [31:0] o_m0_wb_dat;
    logic        o_m0_wb_ack, o_m0_wb_err;
    logic        i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we;
    logic [3:0]  i_m1_wb_sel;
    logic [31:0] i_m1_wb_adr, i_m1_wb_dat;
    logic [31:0] o_m1_wb_dat;
    logic        o_m1_wb_ack, o_m1_wb_err;
    logic        o_s_wb_cyc, o_s_wb_stb, o_s_wb_we;
    logic [3:0]  o_s_wb_sel;
    logic [31:0] o_s_wb_adr, o_s_wb_dat;
    logic [31:0] i_s_wb_dat;
    logic        i_s_wb_ack;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_m0_wb_cyc(i_m0_wb_cyc), .i_m0_wb_stb(i_m0_wb_stb), .i_m0_wb_we(i_m0_wb_we),
        .i_m0_wb_sel(i_m0_wb_sel), .i_m0_wb_adr(i_m0_wb_adr), .i_m0_wb_dat(i_m0_wb_dat),
        .o_m0_wb_dat(o_m0_wb_dat), .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_err(o_m0_wb_err),
        .i_m1_wb_cyc(i_m1_wb_cyc), .i_m1_wb_stb(i_m1_wb_stb), .i_m1_wb_we(i_m1_wb_we),
        .i_m1_wb_sel(i_m1_wb_sel), .i_m1_wb_adr(i_m1_wb_adr), .i_m1_wb_dat(i_m1_wb_dat),
        .o_m1_wb_dat(o_m1_wb_dat), .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_err(o_m1_wb_err),
        .o_s_wb_cyc(o_s_wb_cyc), .o_s_wb_stb(o_s_wb_stb), .o_s_wb_we(o_s_wb_we),
        .o_s_wb_sel(o_s_wb_sel), .o_s_wb_adr(o_s_wb_adr), .o_s_wb_dat(o_s_wb_dat),
        .i_s_wb_dat(i_s_wb_dat), .i_s_wb_ack(i_s_wb_ack),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_masters();
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_m0_wb_we = 0; i_m0_wb_sel = '0;
        i_m0_wb_adr = '0; i_m0_wb_dat = '0;
        i_m1_wb_cyc = 0; i_m1_wb_stb = 0; i_m1_wb_we = 0; i_m1_wb_sel = '0;
        i_m1_wb_adr = '0; i_m1_wb_dat = '0;
        i_s_wb_ack  = 0;
    endtask

    task automatic do_reset();
        clear_masters();
        i_arst = 1;
        #2;
        i_arst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_masters();
        i_s_wb_dat = '0;
        i_arst = 1;
        tick(); tick(); #2;
        check("rst_grant", o_grant, 2'b00);
        check("rst_timeout", o_timeout, 0);
        check("rst_s_cyc", o_s_wb_cyc, 0);
        check("rst_m0_err", o_m0_wb_err, 0);
        i_arst = 0;

        // single master write, ack on the second owned cycle
        tick();
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_we = 1; i_m0_wb_sel = 4'hF;
        i_m0_wb_adr = 32'h8; i_m0_wb_dat = 32'h15;
        #2;
        check("lat_pre_grant", o_grant, 2'b00);
        check("lat_pre_s_cyc", o_s_wb_cyc, 0);
        tick(); #2;
        check("m0_grant", o_grant, 2'b01);
        check("m0_s_cyc", o_s_wb_cyc, 1);
        check("m0_s_adr", o_s_wb_adr, 32'h8);
        check("m0_s_dat", o_s_wb_dat, 32'h15);
        check("m0_s_we", o_s_wb_we, 1);
        check("m0_s_sel", o_s_wb_sel, 4'hF);
        check("m0_ack_early", o_m0_wb_ack, 0);
        tick();
        i_s_wb_ack = 1; i_s_wb_dat = 32'hCAFE0001;
        #2;
        check("m0_ack", o_m0_wb_ack, 1);
        check("m0_rdat", o_m0_wb_dat, 32'hCAFE0001);
        check("m1_ack_idle", o_m1_wb_ack, 0);
        check("m1_rdat_zero", o_m1_wb_dat, 0);
        tick();
        i_s_wb_ack = 0;
        #2;
        check("m0_ack_once", o_m0_wb_ack, 0);

        // owner drops cyc while a late ack arrives
        tick();
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_s_wb_ack = 1;
        #2;
        check("drop_ack", o_m0_wb_ack, 0);
        check("drop_err", o_m0_wb_err, 0);
        check("drop_s_cyc", o_s_wb_cyc, 0);
        tick(); #2;
        check("idle_grant", o_grant, 2'b00);
        check("idle_ack_m0", o_m0_wb_ack, 0);
        check("idle_ack_m1", o_m1_wb_ack, 0);
        tick(); #2;
        check("idle_ack_nostate", o_grant, 2'b00);
        i_s_wb_ack = 0;

        // simultaneous requests: round-robin
        do_reset();
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'h100;
        i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_adr = 32'h200;
        tick(); #2;
        check("rr_first", o_grant, 2'b01);
        check("rr_first_adr", o_s_wb_adr, 32'h100);
        i_s_wb_ack = 1;
        #1;
        check("rr_m0_ack", o_m0_wb_ack, 1);
        check("rr_m1_noack", o_m1_wb_ack, 0);
        tick();
        i_s_wb_ack = 0; i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        #2;
        check("rr_hold", o_grant, 2'b01);
        tick(); #2;
        check("rr_gap", o_grant, 2'b00);
        tick(); #2;
        check("rr_second", o_grant, 2'b10);
        check("rr_second_adr", o_s_wb_adr, 32'h200);
        i_m1_wb_cyc = 0; i_m1_wb_stb = 0;
        tick(); #2;
        check("rr_idle2", o_grant, 2'b00);
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m1_wb_cyc = 1; i_m1_wb_stb = 1;
        tick(); #2;
        check("rr_repeat", o_grant, 2'b01);

        // m1 locks the bus for three beats while m0 keeps requesting
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        tick(); #2;
        check("lock_gap", o_grant, 2'b00);
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1;
        tick(); #2;
        check("lock_grant", o_grant, 2'b10);
        i_s_wb_ack = 1; i_s_wb_dat = 32'h5A5A0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_beat_grant", o_grant, 2'b10);
            check("lock_beat_m1_ack", o_m1_wb_ack, 1);
            check("lock_beat_m0_ack", o_m0_wb_ack, 0);
            check("lock_beat_m0_dat", o_m0_wb_dat, 0);
            tick(); #1;
        end
        i_s_wb_ack = 0; i_m1_wb_cyc = 0; i_m1_wb_stb = 0;
        tick(); #2;
        check("lock_release", o_grant, 2'b00);
        tick(); #2;
        check("lock_next_m0", o_grant, 2'b01);
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        tick();

        // slave never acks: abort after 16 strobe cycles
        do_reset();
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'h40;
        tick(); #2;
        check("to_grant", o_grant, 2'b01);
        for (int i = 1; i <= 16; i++) begin
            check("to_wait_err", o_m0_wb_err, 0);
            check("to_wait_pulse", o_timeout, 0);
            check("to_wait_stb", o_s_wb_stb, 1);
            tick(); #2;
        end
        check("to_err", o_m0_wb_err, 1);
        check("to_pulse", o_timeout, 1);
        check("to_stb_forced", o_s_wb_stb, 0);
        check("to_no_ack", o_m0_wb_ack, 0);
        check("to_keep_grant", o_grant, 2'b01);
        check("to_m1_err", o_m1_wb_err, 0);
        tick(); #2;
        check("to_err_once", o_m0_wb_err, 0);
        check("to_pulse_once", o_timeout, 0);
        check("to_stb_back", o_s_wb_stb, 1);
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        tick(); #2;
        check("to_release", o_grant, 2'b00);

        // ack in the 16th cycle beats the timeout
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1;
        tick(); #2;
        check("ack16_grant", o_grant, 2'b01);
        for (int i = 1; i <= 15; i++) begin
            tick(); #2;
        end
        i_s_wb_ack = 1;
        #1;
        check("ack16_ack", o_m0_wb_ack, 1);
        check("ack16_err", o_m0_wb_err, 0);
        tick();
        i_s_wb_ack = 0;
        #2;
        check("ack16_no_err", o_m0_wb_err, 0);
        check("ack16_no_pulse", o_timeout, 0);
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        tick(); #2;

        // async reset in the middle of an m1 transfer
        i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_we = 1; i_m1_wb_adr = 32'h300;
        i_m1_wb_dat = 32'h77; i_m1_wb_sel = 4'h3;
        tick(); #2;
        check("mid_grant", o_grant, 2'b10);
        i_s_wb_ack = 1;
        #1;
        check("mid_ack", o_m1_wb_ack, 1);
        i_arst = 1;
        #1;
        check("mid_rst_grant", o_grant, 2'b00);
        check("mid_rst_s_cyc", o_s_wb_cyc, 0);
        check("mid_rst_s_stb", o_s_wb_stb, 0);
        check("mid_rst_s_adr", o_s_wb_adr, 0);
        check("mid_rst_s_dat", o_s_wb_dat, 0);
        check("mid_rst_m1_ack", o_m1_wb_ack, 0);
        check("mid_rst_timeout", o_timeout, 0);
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_s_wb_ack = 0;
        i_arst = 0;
        tick(); #2;
        check("post_rst_m0_first", o_grant, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
